// File: rtl/palette_mapper.sv
// Palette lookup: 9-bit pixel index -> registered RGB332, plus aligned hsync/vsync.
// Latency: index->rgb 2 cycles, syncs SYNC_ALIGN+2 cycles.
// Backpressure: CPU writes see pal_wr_busy; they are held until vblank and acked with a one-cycle pulse.
module palette_mapper #(
    parameter int SYNC_ALIGN = 1,
    parameter bit SYNC_IDLE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] bg_index,
    input  logic [8:0] spr_index,
    input  logic       spr_valid,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_in,
    input  logic       vblank_in,
    input  logic       pal_wr_req,
    input  logic [8:0] pal_wr_addr,
    input  logic [7:0] pal_wr_data,
    output logic       pal_wr_busy,
    output logic       pal_wr_ack,
    output logic       init_done,
    output logic [7:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out
);

    localparam int SD = SYNC_ALIGN + 2;

    typedef enum logic [1:0] {INIT, IDLE, PENDING, COMMIT} state_t;

    state_t     state, state_nxt;
    logic [8:0] cnt;
    logic [8:0] req_addr;
    logic [7:0] req_data;
    logic       ram_we;
    logic [8:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [7:0] mem [0:511];
    logic [8:0] sel_d1;
    logic       blank_d1;
    logic [SD-1:0] hs_pipe;
    logic [SD-1:0] vs_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
        end else begin
            state <= state_nxt;
            // counter parks at 511 so it only ever restarts through reset
            if (state == INIT && cnt != 9'd511)
                cnt <= cnt + 9'd1;
            if (state == INIT && cnt == 9'd511)
                init_done <= 1'b1;
            if (state == IDLE && pal_wr_req) begin
                req_addr <= pal_wr_addr;
                req_data <= pal_wr_data;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_we      = 1'b0;
        ram_waddr   = cnt;
        ram_wdata   = cnt[7:0];
        pal_wr_busy = 1'b1;
        pal_wr_ack  = 1'b0;
        case (state)
            INIT: begin
                ram_we = 1'b1;
                if (cnt == 9'd511)
                    state_nxt = IDLE;
            end
            IDLE: begin
                pal_wr_busy = 1'b0;
                if (pal_wr_req)
                    state_nxt = PENDING;
            end
            PENDING: begin
                if (vblank_in)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                ram_we     = 1'b1;
                ram_waddr  = req_addr;
                ram_wdata  = req_data;
                pal_wr_ack = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Non-blocking write keeps a same-cycle read of the same entry on the old value.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_d1   <= '0;
            blank_d1 <= 1'b1;
            rgb_out  <= '0;
        end else begin
            sel_d1   <= spr_valid ? spr_index : bg_index;
            blank_d1 <= blank_in;
            rgb_out  <= (blank_d1 || !init_done) ? 8'h00 : mem[sel_d1];
        end
    end

    // Syncs carry the extra upstream index register delay; they keep running during init.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_pipe <= {SD{SYNC_IDLE}};
            vs_pipe <= {SD{SYNC_IDLE}};
        end else begin
            hs_pipe <= {hs_pipe[SD-2:0], hsync_in};
            vs_pipe <= {vs_pipe[SD-2:0], vsync_in};
        end
    end

    assign hsync_out = hs_pipe[SD-1];
    assign vsync_out = vs_pipe[SD-1];

endmodule

// File: tb/tb_palette_mapper.sv
// Directed bench for palette_mapper: init sequence, vblank-gated writes, sprite select, blank and sync alignment.
module tb_palette_mapper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] bg_index;
    logic [8:0] spr_index;
    logic       spr_valid;
    logic       hsync_in;
    logic       vsync_in;
    logic       blank_in;
    logic       vblank_in;
    logic       pal_wr_req;
    logic [8:0] pal_wr_addr;
    logic [7:0] pal_wr_data;
    logic       pal_wr_busy;
    logic       pal_wr_ack;
    logic       init_done;
    logic [7:0] rgb_out;
    logic       hsync_out;
    logic       vsync_out;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    palette_mapper #(.SYNC_ALIGN(1), .SYNC_IDLE(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bg_index    (bg_index),
        .spr_index   (spr_index),
        .spr_valid   (spr_valid),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_in    (blank_in),
        .vblank_in   (vblank_in),
        .pal_wr_req  (pal_wr_req),
        .pal_wr_addr (pal_wr_addr),
        .pal_wr_data (pal_wr_data),
        .pal_wr_busy (pal_wr_busy),
        .pal_wr_ack  (pal_wr_ack),
        .init_done   (init_done),
        .rgb_out     (rgb_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pal_wr_ack === 1'b1)
            ack_cnt++;
    end

    // Advance n rising edges; inputs are driven and outputs sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bg_index    = 9'd0;
        spr_index   = 9'd0;
        spr_valid   = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        blank_in    = 1'b1;
        vblank_in   = 1'b0;
        pal_wr_req  = 1'b0;
        pal_wr_addr = 9'd0;
        pal_wr_data = 8'd0;
        step(3);
        chk("rst_rgb",   rgb_out,     16'h00);
        chk("rst_busy",  pal_wr_busy, 16'h1);
        chk("rst_ack",   pal_wr_ack,  16'h0);
        chk("rst_init",  init_done,   16'h0);
        chk("rst_hsync", hsync_out,   16'h1);
        chk("rst_vsync", vsync_out,   16'h1);

        // Init: 512 cycles after release; a request in the middle must be dropped.
        rst_n    = 1'b1;
        bg_index = 9'd5;
        blank_in = 1'b0;
        step(200);
        pal_wr_req  = 1'b1;
        pal_wr_addr = 9'd9;
        pal_wr_data = 8'hAA;
        step(1);
        pal_wr_req = 1'b0;
        step(310);
        chk("init_511_done", init_done,   16'h0);
        chk("init_511_busy", pal_wr_busy, 16'h1);
        chk("init_511_rgb",  rgb_out,     16'h00);
        step(1);
        chk("init_512_done", init_done,   16'h1);
        chk("init_512_busy", pal_wr_busy, 16'h0);
        step(1);
        chk("rgb_idx5",      rgb_out,     16'h05);
        chk("init_no_ack",   ack_cnt,     16'd0);
        bg_index = 9'd9;
        step(2);
        chk("rgb_idx9_default", rgb_out, 16'h09);

        // Write held until vblank; a second request while pending is ignored.
        bg_index = 9'd7;
        step(2);
        chk("rgb_idx7_default", rgb_out, 16'h07);
        pal_wr_req  = 1'b1;
        pal_wr_addr = 9'd7;
        pal_wr_data = 8'hE3;
        step(1);
        pal_wr_req = 1'b0;
        chk("pend_busy", pal_wr_busy, 16'h1);
        step(20);
        pal_wr_req  = 1'b1;
        pal_wr_addr = 9'd9;
        pal_wr_data = 8'h1C;
        step(1);
        pal_wr_req = 1'b0;
        step(29);
        chk("pend50_busy", pal_wr_busy, 16'h1);
        chk("pend50_ack",  ack_cnt,     16'd0);
        chk("pend50_rgb",  rgb_out,     16'h07);
        vblank_in = 1'b1;
        step(1);
        chk("commit_ack", pal_wr_ack, 16'h1);
        step(1);
        vblank_in = 1'b0;
        chk("commit_ack_drop", pal_wr_ack,  16'h0);
        chk("commit_idle",     pal_wr_busy, 16'h0);
        step(1);
        chk("rgb_idx7_new", rgb_out, 16'hE3);
        bg_index = 9'd9;
        step(2);
        chk("rgb_idx9_kept", rgb_out, 16'h09);
        chk("one_ack",       ack_cnt, 16'd1);

        // Sprite select including the top entry.
        bg_index  = 9'd5;
        spr_index = 9'h1FF;
        spr_valid = 1'b1;
        step(1);
        chk("spr_latency", rgb_out, 16'h09);
        step(1);
        chk("spr_1ff", rgb_out, 16'hFF);
        spr_valid = 1'b0;
        step(2);
        chk("spr_drop", rgb_out, 16'h05);

        // Blank forces black.
        bg_index = 9'd7;
        blank_in = 1'b1;
        step(2);
        chk("blank_black", rgb_out, 16'h00);
        blank_in = 1'b0;
        step(2);
        chk("unblank", rgb_out, 16'hE3);

        // Sync delay is three cycles.
        hsync_in = 1'b0;
        step(2);
        chk("hsync_2cyc", hsync_out, 16'h1);
        step(1);
        chk("hsync_3cyc", hsync_out, 16'h0);
        hsync_in = 1'b1;
        vsync_in = 1'b0;
        step(2);
        chk("vsync_2cyc", vsync_out, 16'h1);
        step(1);
        chk("vsync_3cyc", vsync_out, 16'h0);
        chk("hsync_back", hsync_out, 16'h1);
        vsync_in = 1'b1;

        // Request accepted while vblank already high commits on the following cycle.
        vblank_in   = 1'b1;
        pal_wr_req  = 1'b1;
        pal_wr_addr = 9'h100;
        pal_wr_data = 8'h5A;
        step(1);
        pal_wr_req = 1'b0;
        chk("vb_pend_ack",  pal_wr_ack,  16'h0);
        chk("vb_pend_busy", pal_wr_busy, 16'h1);
        step(1);
        chk("vb_commit_ack", pal_wr_ack, 16'h1);
        vblank_in = 1'b0;
        bg_index  = 9'h100;
        step(3);
        chk("rgb_idx100_new", rgb_out, 16'h5A);
        chk("two_acks",       ack_cnt, 16'd2);

        // Reset while pending discards the write and reloads defaults.
        pal_wr_req  = 1'b1;
        pal_wr_addr = 9'd7;
        pal_wr_data = 8'h3C;
        step(1);
        pal_wr_req = 1'b0;
        hsync_in   = 1'b0;
        step(5);
        rst_n = 1'b0;
        step(2);
        chk("rst2_busy",  pal_wr_busy, 16'h1);
        chk("rst2_init",  init_done,   16'h0);
        chk("rst2_rgb",   rgb_out,     16'h00);
        chk("rst2_hsync", hsync_out,   16'h1);
        rst_n     = 1'b1;
        vblank_in = 1'b1;
        bg_index  = 9'd7;
        step(511);
        chk("reinit_busy", pal_wr_busy, 16'h1);
        chk("reinit_done0", init_done,  16'h0);
        step(1);
        chk("reinit_done1", init_done, 16'h1);
        step(1);
        chk("reinit_idx7", rgb_out, 16'h07);
        bg_index = 9'h100;
        step(2);
        chk("reinit_idx100", rgb_out, 16'h00);
        step(5);
        chk("rst_no_ack", ack_cnt, 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
